// File: rtl/vector_pkg.sv
// vector_pkg: display-list entry layout, op codes and sequencer state encoding
// shared by the list sequencer and the line drawer.
package vector_pkg;
  localparam int COORD_W = 12;
  localparam int Z_W = 6;
  localparam int ENTRY_W = 32;
  localparam int X_LSB = 0;
  localparam int Y_LSB = 12;
  localparam int Z_LSB = 24;
  localparam int OP_LSB = 30;
  typedef enum logic [1:0] {
    OP_NOP = 2'b00,
    OP_JUMP = 2'b01,
    OP_DRAW = 2'b10,
    OP_END = 2'b11
  } op_e;
  typedef enum logic [2:0] {S_IDLE, S_FETCH, S_WAIT, S_EXEC, S_FRAME_WAIT} seq_state_e;
endpackage

// File: rtl/frame_timer.sv
// frame_timer: saturating cycle counter; expired once it has counted CYCLES-1 since clear.
module frame_timer #(
  parameter int CYCLES = 500000
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  output logic expired
);
  localparam int CW = $clog2(CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(CYCLES - 1);
  logic [CW-1:0] cnt_q, cnt_d;
  assign expired = cnt_q == LAST;
  always_comb cnt_d = clear ? '0 : expired ? cnt_q : cnt_q + CW'(1);
  always_ff @(posedge clk) cnt_q <= !reset ? '0 : cnt_d;
endmodule

// File: rtl/vector_list_sequencer.sv
// vector_list_sequencer: replays a display list from list RAM once per frame,
// issuing jump/draw commands to the line drawer on its ready handshake.
module vector_list_sequencer
  import vector_pkg::*;
#(
  parameter int ADDR_W = 10,
  parameter int MIN_FRAME_CYCLES = 500000
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               enable,
  input  logic [ADDR_W-1:0]  list_base,
  output logic               mem_rd,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic [ENTRY_W-1:0] mem_data,
  output logic [COORD_W-1:0] x,
  output logic [COORD_W-1:0] y,
  output logic [Z_W-1:0]     z,
  output logic               draw,
  output logic               jump,
  input  logic               ready,
  output logic               busy,
  output logic               frame_done,
  output logic               list_overflow
);
  seq_state_e state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ENTRY_W-1:0] entry_q, entry_d;
  logic [COORD_W-1:0] x_q, x_d, y_q, y_d;
  logic [Z_W-1:0] z_q, z_d;
  logic busy_q, busy_d, ovf_q, ovf_d;
  logic timer_clr, expired, go, last;
  op_e op;
  frame_timer #(.CYCLES(MIN_FRAME_CYCLES)) u_timer (
    .clk(clk),
    .reset(reset),
    .clear(timer_clr),
    .expired(expired)
  );
  assign op = op_e'(entry_q[OP_LSB +: 2]);
  // a command issued in the reset cycle would be lost, so the handshake is gated by reset
  assign go = ready & reset;
  assign last = &ptr_q;
  assign mem_addr = ptr_q;
  assign x = x_d;
  assign y = y_d;
  assign z = z_d;
  assign busy = busy_q;
  assign list_overflow = ovf_q;
  always_comb begin
    state_d = state_q;
    ptr_d = ptr_q;
    entry_d = entry_q;
    x_d = x_q;
    y_d = y_q;
    z_d = z_q;
    busy_d = busy_q;
    ovf_d = ovf_q;
    timer_clr = 1'b0;
    mem_rd = 1'b0;
    jump = 1'b0;
    draw = 1'b0;
    frame_done = 1'b0;
    case (state_q)
      S_IDLE:
        if (enable && ready) begin
          ptr_d = list_base;
          timer_clr = 1'b1;
          busy_d = 1'b1;
          state_d = S_FETCH;
        end
      S_FETCH: begin
        mem_rd = 1'b1;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        entry_d = mem_data;
        state_d = S_EXEC;
      end
      S_EXEC:
        if (op == OP_END) state_d = S_FRAME_WAIT;
        else if (op == OP_NOP || go) begin
          jump = op == OP_JUMP;
          draw = op == OP_DRAW;
          if (op != OP_NOP) begin
            x_d = entry_q[X_LSB +: COORD_W];
            y_d = entry_q[Y_LSB +: COORD_W];
            z_d = entry_q[Z_LSB +: Z_W];
          end
          ptr_d = ptr_q + ADDR_W'(1);
          // running off the top of the address space ends the frame like END
          ovf_d = ovf_q | last;
          state_d = last ? S_FRAME_WAIT : S_FETCH;
        end
      S_FRAME_WAIT:
        if (expired && go) begin
          frame_done = 1'b1;
          ptr_d = list_base;
          timer_clr = enable;
          busy_d = enable;
          state_d = enable ? S_FETCH : S_IDLE;
        end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state_q <= S_IDLE;
      ptr_q <= '0;
      entry_q <= '0;
      x_q <= '0;
      y_q <= '0;
      z_q <= '0;
      busy_q <= 1'b0;
      ovf_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q <= ptr_d;
      entry_q <= entry_d;
      x_q <= x_d;
      y_q <= y_d;
      z_q <= z_d;
      busy_q <= busy_d;
      ovf_q <= ovf_d;
    end
endmodule

// File: tb/tb_vector_list_sequencer.sv
// tb_vector_list_sequencer: directed and randomized display lists checked against a list-walking model.
module tb_vector_list_sequencer;
  localparam int AW = 4;
  localparam int MINC = 64;
  localparam logic [1:0] NOP = 2'b00, JMP = 2'b01, DRW = 2'b10, ENDL = 2'b11;
  typedef struct {
    bit d;
    logic [11:0] x;
    logic [11:0] y;
    logic [5:0] z;
    int t;
  } cmd_t;
  logic clk = 0, reset = 0, enable = 0, ready = 0;
  logic [AW-1:0] list_base = '0;
  logic mem_rd;
  logic [AW-1:0] mem_addr;
  logic [31:0] mem_data = '0;
  logic [11:0] x, y;
  logic [5:0] z;
  logic draw, jump, busy, frame_done, list_overflow;
  logic [31:0] ram[16];
  logic [11:0] lx = 0, ly = 0;
  logic [5:0] lz = 0;
  bit ovf_seen = 0, exp_ovf;
  int exp_n;
  cmd_t exp_q[$];
  int compared = 0, mismatched = 0;
  vector_list_sequencer #(.ADDR_W(AW), .MIN_FRAME_CYCLES(MINC)) dut (
    .clk(clk), .reset(reset), .enable(enable), .list_base(list_base),
    .mem_rd(mem_rd), .mem_addr(mem_addr), .mem_data(mem_data),
    .x(x), .y(y), .z(z), .draw(draw), .jump(jump), .ready(ready),
    .busy(busy), .frame_done(frame_done), .list_overflow(list_overflow)
  );
  always #5 clk = ~clk;
  always @(posedge clk) if (mem_rd) mem_data <= ram[mem_addr];
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp)
    else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask
  function automatic logic [31:0] ent(input logic [1:0] op, input int xx, input int yy, input int zz);
    return {op, zz[5:0], yy[11:0], xx[11:0]};
  endfunction
  // Walk the list from base the way software reads it: stop at END or after the top address.
  task automatic model(input logic [AW-1:0] base);
    logic [31:0] e;
    exp_q.delete();
    exp_ovf = 0;
    exp_n = 0;
    for (int a = int'(base); a < 16; a++) begin
      e = ram[a];
      exp_n++;
      if (e[31:30] == ENDL) return;
      if (e[31:30] != NOP) exp_q.push_back('{e[31:30] == DRW, e[11:0], e[23:12], e[29:24], 3 * (a - int'(base)) + 2});
      if (a == 15) exp_ovf = 1;
    end
  endtask
  // Entered at the start of the frame's first FETCH cycle; returns at the start of the cycle after frame_done.
  // mode 0: ready high; 1: random ready; 2: ready dropped for 7 cycles after every pulse.
  task automatic run_frame(input logic [AW-1:0] base, input logic [AW-1:0] nb, input bit en, input int mode);
    int t, k, hold, prev;
    bit done;
    cmd_t c;
    t = 0; k = 0; hold = 0; prev = 0; done = 0;
    model(base);
    ovf_seen |= exp_ovf;
    while (!done) begin
      if (t == 1) begin
        list_base = nb;
        enable = en;
      end
      if (hold > 0) begin
        ready = 0;
        hold--;
      end else ready = (mode == 1) ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      if (t == 0) chk("fetch_start", {mem_rd, mem_addr, busy}, {1'b1, base, 1'b1});
      if (draw || jump) begin
        if (k < exp_q.size()) begin
          c = exp_q[k];
          chk("kind", {jump, draw}, {!c.d, c.d});
          chk("xyz", {x, y, z}, {c.x, c.y, c.z});
          chk("ready_at_pulse", ready, 1);
          if (mode == 0) chk("pulse_time", t, c.t);
          if (mode == 2) chk("pulse_time", t, k == 0 ? c.t : prev + 8);
          {lx, ly, lz} = {c.x, c.y, c.z};
        end else begin
          chk("extra_pulse", k + 1, exp_q.size());
          {lx, ly, lz} = {x, y, z};
        end
        k++;
        prev = t;
        if (mode == 2) hold = 7;
      end else chk("hold_xyz", {x, y, z}, {lx, ly, lz});
      if (frame_done) begin
        done = 1;
        chk("cmd_count", k, exp_q.size());
        chk("overflow", list_overflow, ovf_seen);
        if (mode == 0) chk("done_time", t, 3 * exp_n > MINC - 1 ? 3 * exp_n : MINC - 1);
      end else if (t >= 3000) begin
        chk("frame_timeout", t, 0);
        done = 1;
      end
      @(posedge clk); #1;
      t++;
    end
  endtask
  task automatic idle_check();
    repeat (3) begin
      @(negedge clk);
      chk("idle", {busy, mem_rd, draw, jump, frame_done}, 0);
      @(posedge clk); #1;
    end
  endtask
  initial begin
    logic [AW-1:0] b, nb;
    for (int i = 0; i < 16; i++) ram[i] = {ENDL, 30'd0};
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_outputs", {mem_rd, mem_addr, x, y, z, draw, jump, busy, frame_done, list_overflow}, 0);
    ram[0] = ent(JMP, 10, 20, 5);
    ram[1] = ent(DRW, 100, 20, 63);
    ram[2] = {ENDL, 30'd0};
    @(posedge clk); #1;
    reset = 1; enable = 1; ready = 1; list_base = 0;
    @(posedge clk); #1;
    run_frame(0, 0, 1, 0);
    run_frame(0, 0, 1, 2);
    ram[1] = {NOP, 30'd0};
    ram[2] = ent(DRW, 100, 20, 63);
    ram[3] = {ENDL, 30'd0};
    run_frame(0, 0, 1, 0);
    ram[8] = ent(DRW, 7, 8, 9);
    ram[9] = {ENDL, 30'd0};
    run_frame(0, 8, 1, 0);
    run_frame(8, 8, 1, 0);
    ram[14] = ent(DRW, 1, 2, 3);
    ram[15] = ent(DRW, 4095, 4000, 60);
    run_frame(8, 14, 1, 0);
    run_frame(14, 14, 1, 0);
    run_frame(14, 14, 0, 0);
    idle_check();
    enable = 1; ready = 1; list_base = 0;
    @(posedge clk); #1;
    ready = 0;
    repeat (3) begin
      @(negedge clk);
      chk("no_pulse_wait", {draw, jump}, 0);
      @(posedge clk); #1;
    end
    reset = 0;
    @(negedge clk);
    chk("exec_waiting", {busy, draw, jump}, 3'b100);
    @(posedge clk); #1;
    @(negedge clk);
    chk("reset_midframe", {mem_rd, mem_addr, x, y, z, draw, jump, busy, frame_done, list_overflow}, 0);
    @(posedge clk); #1;
    reset = 1; ready = 1; enable = 1; list_base = 0;
    {lx, ly, lz} = 0;
    ovf_seen = 0;
    @(posedge clk); #1;
    run_frame(0, 0, 1, 0);
    b = 0;
    for (int r = 0; r < 8; r++) begin
      for (int i = 0; i < 16; i++)
        ram[i] = ent(2'($urandom_range(0, 3)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 4095)), int'($urandom_range(0, 63)));
      nb = AW'($urandom_range(0, 15));
      run_frame(b, nb, 1, r % 2);
      b = nb;
    end
    run_frame(b, b, 0, 0);
    idle_check();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
